// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared source indices, default sizes and conflict counter width
// Purpose : constants shared by the bus select logic and anything that drives
//           src_en by name (R0..R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN).
// Ports   : none (package).
package bus_pkg;

    // Source indices on the shared bus
    localparam int R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3;
    localparam int R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
    localparam int R8  = 8,  R9  = 9,  R10 = 10, R11 = 11;
    localparam int R12 = 12, R13 = 13, R14 = 14, R15 = 15;
    localparam int HI     = 16;
    localparam int LO     = 17;
    localparam int ZHI    = 18;
    localparam int ZLO    = 19;
    localparam int PC     = 20;
    localparam int MDR    = 21;
    localparam int INPORT = 22;
    localparam int CSIGN  = 23;

    // Default geometry
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NSRC  = 24;

    // Conflict counter
    localparam int                      CONFLICT_CNT_W   = 8;
    localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-index-wins priority encoder with any/multi flags
// Purpose : encodes an N-bit enable vector into the index of its lowest set
//           bit and flags whether any bit, or more than one bit, is set.
// Ports   : i_vec   - enable vector
//           o_idx   - index of lowest set bit (0 when none set)
//           o_any   - at least one bit set
//           o_multi - two or more bits set
module prio_enc #(
    parameter  int N  = 24,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any,
    output logic          o_multi
);

    // Scan from the top down so the lowest set bit is the last to assign
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IW'(i);
            end
        end
    end

    assign o_any   = |i_vec;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign o_multi = |(i_vec & (i_vec - N'(1)));

endmodule

// File: rtl/bus_select_reg.sv
// rtl/bus_select_reg.sv - priority-selected shared bus with conflict tracking
// Purpose : drives one of NSRC source words onto the bus (lowest enabled index
//           wins), optionally registered, with optional idle-hold, and keeps a
//           sticky conflict flag plus a saturating conflict-cycle counter.
// Ports   : clk, clr (async active-low reset)
//           src_data[NSRC*WIDTH], src_en[NSRC], err_clr
//           bus_out[WIDTH], bus_valid, bus_src[clog2(NSRC)]
//           conflict, conflict_cnt[8]
module bus_select_reg
    import bus_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int NSRC  = DEFAULT_NSRC,
    parameter  int PIPE  = 1,
    parameter  int HOLD  = 0,
    localparam int SW    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [NSRC*WIDTH-1:0]     src_data,
    input  logic [NSRC-1:0]           src_en,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          bus_out,
    output logic                      bus_valid,
    output logic [SW-1:0]             bus_src,
    output logic                      conflict,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    logic [SW-1:0]    w_idx;
    logic             w_any;
    logic             w_multi;
    logic [WIDTH-1:0] w_sel;

    prio_enc #(.N(NSRC)) u_prio_enc (
        .i_vec   (src_en),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    assign w_sel = src_data[w_idx*WIDTH +: WIDTH];

    generate
        if (PIPE != 0) begin : g_pipe
            logic [WIDTH-1:0] r_out;
            logic             r_valid;
            logic [SW-1:0]    r_src;

            // r_out doubles as the held value when HOLD is set
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_out   <= '0;
                    r_valid <= 1'b0;
                    r_src   <= '0;
                end else begin
                    r_valid <= w_any;
                    if (w_any) begin
                        r_out <= w_sel;
                        r_src <= w_idx;
                    end else if (HOLD == 0) begin
                        r_out <= '0;
                    end
                end
            end

            assign bus_out   = r_out;
            assign bus_valid = r_valid;
            assign bus_src   = r_src;
        end else begin : g_comb
            logic [WIDTH-1:0] r_word;
            logic [SW-1:0]    r_src;

            // Only the idle-time values are registered; the live path is pure logic
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    r_word <= '0;
                    r_src  <= '0;
                end else if (w_any) begin
                    r_word <= w_sel;
                    r_src  <= w_idx;
                end
            end

            assign bus_out   = w_any ? w_sel : ((HOLD != 0) ? r_word : '0);
            assign bus_valid = w_any;
            assign bus_src   = w_any ? w_idx : r_src;
        end
    endgenerate

    logic                      r_conflict;
    logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

    // err_clr takes precedence over a conflict seen at the same edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (err_clr) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (w_multi) begin
            r_conflict <= 1'b1;
            if (r_conflict_cnt != CONFLICT_CNT_MAX) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign conflict     = r_conflict;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bus_select_reg.sv
// tb/tb_bus_select_reg.sv - scoreboard bench over four parameter sets of bus_select_reg
module tb_bus_select_reg;

    localparam int ND = 4;

    typedef struct packed {
        logic [63:0] out;
        logic        valid;
        logic [5:0]  src;
        logic        conf;
        logic [7:0]  cnt;
    } exp_t;

    int DW[ND] = '{32, 32, 16, 64};
    int DN[ND] = '{24, 24, 4, 40};
    int DP[ND] = '{1, 0, 1, 0};
    int DH[ND] = '{0, 1, 1, 0};

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        err_clr = 1'b0;
    logic [39:0] en = '0;
    logic [63:0] words[40];
    logic [63:0] nw[40];

    always #5 clk = ~clk;

    // DUT 0: 32/24 PIPE=1 HOLD=0
    logic [24*32-1:0] d0;
    logic [31:0] o0; logic v0; logic [4:0] s0; logic c0; logic [7:0] n0;
    always_comb for (int i = 0; i < 24; i++) d0[i*32 +: 32] = words[i][31:0];
    bus_select_reg #(.WIDTH(32), .NSRC(24), .PIPE(1), .HOLD(0)) u0 (
        .clk(clk), .clr(clr), .src_data(d0), .src_en(en[23:0]), .err_clr(err_clr),
        .bus_out(o0), .bus_valid(v0), .bus_src(s0), .conflict(c0), .conflict_cnt(n0));

    // DUT 1: 32/24 PIPE=0 HOLD=1
    logic [24*32-1:0] d1;
    logic [31:0] o1; logic v1; logic [4:0] s1; logic c1; logic [7:0] n1;
    always_comb for (int i = 0; i < 24; i++) d1[i*32 +: 32] = words[i][31:0];
    bus_select_reg #(.WIDTH(32), .NSRC(24), .PIPE(0), .HOLD(1)) u1 (
        .clk(clk), .clr(clr), .src_data(d1), .src_en(en[23:0]), .err_clr(err_clr),
        .bus_out(o1), .bus_valid(v1), .bus_src(s1), .conflict(c1), .conflict_cnt(n1));

    // DUT 2: 16/4 PIPE=1 HOLD=1
    logic [4*16-1:0] d2;
    logic [15:0] o2; logic v2; logic [1:0] s2; logic c2; logic [7:0] n2;
    always_comb for (int i = 0; i < 4; i++) d2[i*16 +: 16] = words[i][15:0];
    bus_select_reg #(.WIDTH(16), .NSRC(4), .PIPE(1), .HOLD(1)) u2 (
        .clk(clk), .clr(clr), .src_data(d2), .src_en(en[3:0]), .err_clr(err_clr),
        .bus_out(o2), .bus_valid(v2), .bus_src(s2), .conflict(c2), .conflict_cnt(n2));

    // DUT 3: 64/40 PIPE=0 HOLD=0
    logic [40*64-1:0] d3;
    logic [63:0] o3; logic v3; logic [5:0] s3; logic c3; logic [7:0] n3;
    always_comb for (int i = 0; i < 40; i++) d3[i*64 +: 64] = words[i];
    bus_select_reg #(.WIDTH(64), .NSRC(40), .PIPE(0), .HOLD(0)) u3 (
        .clk(clk), .clr(clr), .src_data(d3), .src_en(en), .err_clr(err_clr),
        .bus_out(o3), .bus_valid(v3), .bus_src(s3), .conflict(c3), .conflict_cnt(n3));

    exp_t act[ND];
    always_comb begin
        act[0].out = 64'(o0); act[0].valid = v0; act[0].src = 6'(s0); act[0].conf = c0; act[0].cnt = n0;
        act[1].out = 64'(o1); act[1].valid = v1; act[1].src = 6'(s1); act[1].conf = c1; act[1].cnt = n1;
        act[2].out = 64'(o2); act[2].valid = v2; act[2].src = 6'(s2); act[2].conf = c2; act[2].cnt = n2;
        act[3].out = o3;      act[3].valid = v3; act[3].src = s3;     act[3].conf = c3; act[3].cnt = n3;
    end

    // Reference model state: last word put on the bus, last source, conflict
    logic [63:0] m_last[ND];
    logic [5:0]  m_src[ND];
    logic        m_conf[ND];
    int          m_cnt[ND];

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, int k, logic [63:0] a, logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, a, e);
        end
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue what each DUT
    // should show just after the following rising edge.
    task automatic step(input logic c, input logic [39:0] e, input logic ec);
        @(negedge clk);
        for (int i = 0; i < 40; i++) words[i] = nw[i];
        clr = c; en = e; err_clr = ec;
        for (int k = 0; k < ND; k++) begin
            logic [63:0] wm;
            logic [39:0] em;
            int sel;
            exp_t x;
            wm = (64'd1 << DW[k]) - 64'd1;
            em = e & ((40'd1 << DN[k]) - 40'd1);
            sel = -1;
            for (int i = 0; i < 40; i++) if (em[i] && sel < 0) sel = i;
            x = '0;
            if (!c) begin
                m_last[k] = '0; m_src[k] = '0; m_conf[k] = 1'b0; m_cnt[k] = 0;
                if (DP[k] == 0 && sel >= 0) begin
                    x.out = words[sel] & wm; x.valid = 1'b1; x.src = 6'(sel);
                end
            end else begin
                if (ec) begin
                    m_conf[k] = 1'b0; m_cnt[k] = 0;
                end else if ($countones(em) >= 2) begin
                    m_conf[k] = 1'b1;
                    m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                end
                if (sel >= 0) begin
                    m_last[k] = words[sel] & wm;
                    m_src[k]  = 6'(sel);
                    x.out = m_last[k]; x.valid = 1'b1;
                end else begin
                    x.out = (DH[k] != 0) ? m_last[k] : 64'd0; x.valid = 1'b0;
                end
                x.src  = m_src[k];
                x.conf = m_conf[k];
                x.cnt  = 8'(m_cnt[k]);
            end
            q.push_back(x);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and scores queued expectations
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() >= ND) begin
                for (int k = 0; k < ND; k++) begin
                    exp_t x;
                    x = q.pop_front();
                    chk("bus_out",      k, act[k].out,          x.out);
                    chk("bus_valid",    k, 64'(act[k].valid),   64'(x.valid));
                    chk("bus_src",      k, 64'(act[k].src),     64'(x.src));
                    chk("conflict",     k, 64'(act[k].conf),    64'(x.conf));
                    chk("conflict_cnt", k, 64'(act[k].cnt),     64'(x.cnt));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 40; i++) begin
            nw[i] = {$urandom, $urandom};
            words[i] = nw[i];
        end
        for (int k = 0; k < ND; k++) begin
            m_last[k] = '0; m_src[k] = '0; m_conf[k] = 1'b0; m_cnt[k] = 0;
        end

        // Reset held with source 5 enabled, then release
        repeat (3) step(1'b0, 40'd1 << 5, 1'b0);
        step(1'b1, 40'd1 << 5, 1'b0);

        // PC word through the bus
        nw[20] = 64'h0000_1234;
        step(1'b1, 40'd1 << 20, 1'b0);
        step(1'b1, 40'd0, 1'b0);

        // Priority with conflict: sources 3 and 21
        step(1'b1, (40'd1 << 3) | (40'd1 << 21), 1'b0);

        // Idle after 0xDEADBEEF on source 2
        nw[2] = 64'h0000_0000_DEAD_BEEF;
        step(1'b1, 40'd1 << 2, 1'b0);
        step(1'b1, 40'd0, 1'b0);
        nw[2] = 64'h1111_2222_3333_4444;
        step(1'b1, 40'd0, 1'b0);

        // Saturation then clear coinciding with a conflict
        repeat (300) step(1'b1, 40'h3, 1'b0);
        step(1'b1, 40'h3, 1'b1);
        step(1'b1, 40'd0, 1'b0);

        // Reset mid-transfer discards the in-flight word
        step(1'b1, 40'd1 << 1, 1'b0);
        step(1'b0, 40'd1 << 1, 1'b0);
        step(1'b1, 40'd0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [39:0] e;
            int mode;
            nw[$urandom_range(0, 39)] = {$urandom, $urandom};
            mode = $urandom_range(0, 3);
            case (mode)
                0: e = '0;
                1: e = 40'd1 << $urandom_range(0, 39);
                2: e = 40'({$urandom, $urandom});
                default: e = (40'd1 << $urandom_range(0, 39)) | (40'd1 << $urandom_range(0, 5));
            endcase
            step(($urandom_range(0, 63) != 0), e, ($urandom_range(0, 15) == 0));
        end
        step(1'b1, 40'd0, 1'b0);

        @(posedge clk);
        #2;
        chk("queue_drained", 0, 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_select_reg.md
BUS_SELECT_REG -- requirements
Module: bus_select_reg

Interface
REQ-001 Parameter WIDTH, default 32, bit width of every source and of the bus.
REQ-002 Parameter NSRC, default 24, number of bus sources (legal range 2..64).
REQ-003 Parameter PIPE, default 1; 0 = combinational bus path, 1 = registered bus path (one-cycle latency).
REQ-004 Parameter HOLD, default 0; 0 = idle bus drives zero, 1 = idle bus keeps its last driven value.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 clr  input  1  asynchronous, active-low reset.
REQ-007 src_data  input  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 src_en  input  NSRC  per-source out-enable, intended one-hot (e.g. R0out..Cout).
REQ-009 err_clr  input  1  synchronous clear of conflict flag and counter.
REQ-010 bus_out  output  WIDTH  selected bus word.
REQ-011 bus_valid  output  1  bus_out carries a source word this cycle.
REQ-012 bus_src  output  clog2(NSRC)  index of the source currently on bus_out.
REQ-013 conflict  output  1  sticky flag: more than one src_en bit was seen high.
REQ-014 conflict_cnt  output  8  saturating count of conflict cycles.

Function
REQ-015 Selection SHALL be by priority: the lowest asserted src_en index wins; higher asserted indices are ignored.
REQ-016 With PIPE=1, bus_out/bus_valid/bus_src SHALL reflect the src_en/src_data sampled at the previous rising edge (latency 1).
REQ-017 With PIPE=0, bus_out/bus_valid/bus_src SHALL follow src_en/src_data combinationally (latency 0).
REQ-018 When src_en is all-zero, bus_valid SHALL be 0 and bus_src SHALL hold its previous value.
REQ-019 When src_en is all-zero and HOLD=0, bus_out SHALL be 0; with HOLD=1 it SHALL equal the last word presented with bus_valid=1 (0 if none since reset).
REQ-020 HOLD=1 SHALL require PIPE=1 or an internal last-value register; either way the held value SHALL be registered.
REQ-021 A cycle with two or more src_en bits high SHALL set conflict at the next edge and increment conflict_cnt by 1.
REQ-022 conflict_cnt SHALL saturate at 255 and not wrap.
REQ-023 err_clr high at an edge SHALL clear conflict and conflict_cnt to 0; if a conflict occurs in the same cycle, clear wins and the counter ends at 0.
REQ-024 Conflict logic SHALL be registered irrespective of PIPE.
REQ-025 Bus selection SHALL still be performed (per REQ-015) in a conflict cycle; conflict never suppresses bus_valid.

Reset
REQ-026 clr low SHALL immediately force bus_out=0, bus_valid=0, bus_src=0, conflict=0, conflict_cnt=0 and the held value to 0, regardless of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the in-flight word; first valid output after clr release requires a fresh src_en sample.
REQ-028 In PIPE=0 the combinational bus path SHALL be unaffected by clr except for the HOLD register.

Structure
REQ-029 Shared package bus_pkg SHALL hold source-index constants (R0..R15=0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23), default WIDTH/NSRC, and the conflict counter width.
REQ-030 One sub-module prio_enc (NSRC-bit vector -> index, any-bit, multi-bit flags) SHALL perform encoding and conflict detection.

Verification
REQ-031 Reset: clr low with src_en=1<<5 active -> all outputs 0 while low; after release, first edge gives bus_out=src5, bus_src=5, bus_valid=1 (PIPE=1).
REQ-032 Latency: PIPE=1, src_en=1<<20 (PC=0x0000_1234) at edge N -> bus_out=0x0000_1234, bus_src=20 after edge N; PIPE=0 -> same value in the same cycle.
REQ-033 Priority/conflict: src_en bits 3 and 21 high one cycle -> bus_src=3, bus_valid=1, conflict=1, conflict_cnt=1.
REQ-034 Idle: after driving 0xDEAD_BEEF, src_en=0 -> bus_out=0 (HOLD=0) or 0xDEAD_BEEF (HOLD=1), bus_valid=0, bus_src unchanged.
REQ-035 Saturation/clear: 300 consecutive conflict cycles -> conflict_cnt=255; err_clr with simultaneous conflict -> conflict_cnt=0, conflict=0.
REQ-036 Parameter sweep: WIDTH=16/NSRC=4 and WIDTH=64/NSRC=40 rerun REQ-031..035 with all outputs matching a reference model.
